// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing the daisy-chained core bus between
// requesters A and B. A tag pipeline matched to CHAIN_LATENCY tracks which
// requester owns each in-flight word so returns can be routed back.
// Optional feature macro: BUS_ARBITER_CHECK_EN. When it is defined, err_o flags
// return/tag mismatches and address mismatches. When it is undefined, err_o is 0.
module bus_arbiter #(
    parameter int CHAIN_LATENCY  = 2,
    parameter bit START_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [15:0] a_req_addr,
    input  logic [15:0] a_req_data,
    input  logic        a_req_rw,
    output logic        a_resp_valid,
    output logic [15:0] a_resp_addr,
    output logic [15:0] a_resp_data,
    output logic        a_resp_rw,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [15:0] b_req_addr,
    input  logic [15:0] b_req_data,
    input  logic        b_req_rw,
    output logic        b_resp_valid,
    output logic [15:0] b_resp_addr,
    output logic [15:0] b_resp_data,
    output logic        b_resp_rw,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic        err_o
);

    localparam int                DEPTH      = CHAIN_LATENCY + 1;
    localparam int                CNT_W      = $clog2(CHAIN_LATENCY + 2);
    localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(CHAIN_LATENCY + 1);

    logic [CNT_W-1:0] flush_cnt;
    logic             flush_busy;
    logic             last_grant;      // 0 = A, 1 = B
    logic             grant_a;
    logic             grant_b;
    logic             xfer;
    logic             xfer_owner;
    logic [15:0]      xfer_addr;
    logic [15:0]      xfer_data;
    logic             xfer_rw;

    // Tag pipeline: bit 0 is loaded at the transfer, bit DEPTH-1 lines up with valid_i
    logic [DEPTH-1:0] tag_vld;
    logic [DEPTH-1:0] tag_own;
    logic             ret_live;
    logic             ret_own;
    logic             route;

    logic [15:0]      resp_addr;
    logic [15:0]      resp_data;
    logic             resp_rw;

    assign flush_busy = (flush_cnt != '0);

    // Round-robin grant: a contended cycle goes to whoever did not win last
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && !flush_busy) begin
            if (a_req_valid && b_req_valid) begin
                grant_a = last_grant;
                grant_b = !last_grant;
            end else begin
                grant_a = a_req_valid;
                grant_b = b_req_valid;
            end
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign xfer        = grant_a || grant_b;
    assign xfer_owner  = grant_b;
    assign xfer_addr   = grant_b ? b_req_addr : a_req_addr;
    assign xfer_data   = grant_b ? b_req_data : a_req_data;
    assign xfer_rw     = grant_b ? b_req_rw   : a_req_rw;

    // Post-reset flush countdown and round-robin history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt  <= FLUSH_LOAD;
            last_grant <= ~START_PRIORITY;
        end else begin
            if (flush_busy) flush_cnt <= flush_cnt - CNT_W'(1);
            if (xfer) last_grant <= xfer_owner;
        end
    end

    // Chain head: launch the granted payload; payload holds when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            rw_o    <= 1'b0;
        end else begin
            valid_o <= xfer;
            if (xfer) begin
                addr_o <= xfer_addr;
                data_o <= xfer_data;
                rw_o   <= xfer_rw;
            end
        end
    end

    // Tag live bits; dropping them on reset orphans any in-flight returns
    always_ff @(posedge clk) begin
        if (!rst_n) tag_vld <= '0;
        else        tag_vld <= {tag_vld[DEPTH-2:0], xfer};
    end

    // Tag owner bits only matter while the matching live bit is set
    always_ff @(posedge clk) begin
        tag_own <= {tag_own[DEPTH-2:0], xfer_owner};
    end

    assign ret_live = tag_vld[DEPTH-1];
    assign ret_own  = tag_own[DEPTH-1];
    assign route    = valid_i && ret_live && !flush_busy;

    // Response stage: strobe the owning requester, capture the returning word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            resp_addr    <= '0;
            resp_data    <= '0;
            resp_rw      <= 1'b0;
        end else begin
            a_resp_valid <= route && !ret_own;
            b_resp_valid <= route && ret_own;
            if (route) begin
                resp_addr <= addr_i;
                resp_data <= data_i;
                resp_rw   <= rw_i;
            end
        end
    end

    assign a_resp_addr = resp_addr;
    assign a_resp_data = resp_data;
    assign a_resp_rw   = resp_rw;
    assign b_resp_addr = resp_addr;
    assign b_resp_data = resp_data;
    assign b_resp_rw   = resp_rw;

`ifdef BUS_ARBITER_CHECK_EN
    logic [15:0] tag_addr [DEPTH];
    logic        mismatch;
    logic        err_q;

    // Address copy travels with each tag so returns can be cross-checked
    always_ff @(posedge clk) begin
        tag_addr[0] <= xfer_addr;
        for (int k = 1; k < DEPTH; k++) tag_addr[k] <= tag_addr[k-1];
    end

    assign mismatch = !flush_busy &&
                      ((valid_i != ret_live) ||
                       (valid_i && ret_live && (addr_i != tag_addr[DEPTH-1])));

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)        err_q <= 1'b0;
        else if (mismatch) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter with a fixed-latency chain model.
// Expected values are hand-derived; read data for address A is 0x1234 at
// 0x0003, otherwise A ^ 0xA5A5. Writes echo their data.
module tb_bus_arbiter;

    localparam int LAT = 2;
`ifdef BUS_ARBITER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_rw;
    logic [15:0] a_req_addr, a_req_data;
    logic        a_resp_valid, a_resp_rw;
    logic [15:0] a_resp_addr, a_resp_data;
    logic        b_req_valid, b_req_ready, b_req_rw;
    logic [15:0] b_req_addr, b_req_data;
    logic        b_resp_valid, b_resp_rw;
    logic [15:0] b_resp_addr, b_resp_data;
    logic [15:0] addr_o, data_o, addr_i, data_i;
    logic        rw_o, valid_o, rw_i, valid_i, err_o;
    logic        inj;

    always #5 clk = ~clk;

    bus_arbiter #(.CHAIN_LATENCY(LAT), .START_PRIORITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
        .a_req_data(a_req_data), .a_req_rw(a_req_rw),
        .a_resp_valid(a_resp_valid), .a_resp_addr(a_resp_addr), .a_resp_data(a_resp_data),
        .a_resp_rw(a_resp_rw),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
        .b_req_data(b_req_data), .b_req_rw(b_req_rw),
        .b_resp_valid(b_resp_valid), .b_resp_addr(b_resp_addr), .b_resp_data(b_resp_data),
        .b_resp_rw(b_resp_rw),
        .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .err_o(err_o)
    );

    // Chain model: pure LAT-cycle delay line, never reset
    logic        cv [LAT];
    logic [15:0] ca [LAT];
    logic [15:0] cd [LAT];
    logic        cr [LAT];

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        return (a == 16'h0003) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    always @(posedge clk) begin
        cv[0] <= valid_o; ca[0] <= addr_o; cd[0] <= data_o; cr[0] <= rw_o;
        for (int k = 1; k < LAT; k++) begin
            cv[k] <= cv[k-1]; ca[k] <= ca[k-1]; cd[k] <= cd[k-1]; cr[k] <= cr[k-1];
        end
    end

    assign valid_i = cv[LAT-1] | inj;
    assign addr_i  = ca[LAT-1];
    assign rw_i    = cr[LAT-1];
    assign data_i  = cr[LAT-1] ? cd[LAT-1] : mem_read(ca[LAT-1]);

    // Response monitor
    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
        int          cyc;
    } resp_t;

    resp_t rq[$];
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_resp_valid) rq.push_back('{port: 1'b0, addr: a_resp_addr, data: a_resp_data, rw: a_resp_rw, cyc: cyc});
        if (b_resp_valid) rq.push_back('{port: 1'b1, addr: b_resp_addr, data: b_resp_data, rw: b_resp_rw, cyc: cyc});
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    base;
        int    n;
        resp_t e;
        logic [15:0] exp_addr [6];
        logic        exp_port [6];

        rst_n = 1'b0; inj = 1'b0;
        a_req_valid = 1'b1; a_req_addr = 16'h0003; a_req_data = 16'h0; a_req_rw = 1'b0;
        b_req_valid = 1'b0; b_req_addr = 16'h0;    b_req_data = 16'h0; b_req_rw = 1'b0;

        // ---- reset state (third reset cycle) ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {valid_o, rw_o, a_req_ready, b_req_ready, a_resp_valid, b_resp_valid,
                           a_resp_rw, b_resp_rw, err_o}, 0);
        check("rst_addr_o", addr_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_resp_addr", a_resp_addr, 0);
        check("rst_resp_data", b_resp_data, 0);
        tick();
        rst_n = 1'b1;

        // ---- flush window: ready low for LAT+1 cycles ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_rdy_a", a_req_ready, 0);
            check("flush_rdy_b", b_req_ready, 0);
            tick();
        end

        // ---- single read via A ----
        @(negedge clk);
        check("rd_rdy_a", a_req_ready, 1);
        check("rd_rdy_b", b_req_ready, 0);
        base = rq.size();
        tick();
        a_req_valid = 1'b0;
        @(negedge clk);
        check("rd_valid_o", valid_o, 1);
        check("rd_addr_o", addr_o, 16'h0003);
        check("rd_rw_o", rw_o, 0);
        tick();
        @(negedge clk);
        check("rd_idle_valid_o", valid_o, 0);
        check("rd_addr_hold", addr_o, 16'h0003);
        check("rd_early_n2", a_resp_valid, 0);
        tick();
        @(negedge clk);
        check("rd_early_n3", a_resp_valid, 0);
        tick();
        @(negedge clk);
        check("rd_resp_valid", a_resp_valid, 1);
        check("rd_resp_data", a_resp_data, 16'h1234);
        check("rd_resp_addr", a_resp_addr, 16'h0003);
        check("rd_resp_rw", a_resp_rw, 0);
        check("rd_b_quiet", b_resp_valid, 0);
        tick();
        @(negedge clk);
        check("rd_resp_once", a_resp_valid, 0);
        check("rd_count", rq.size() - base, 1);

        // ---- back-to-back writes from B ----
        tick();
        base = rq.size();
        for (int i = 0; i < 8; i++) begin
            b_req_valid = 1'b1;
            b_req_addr  = 16'h0010 + 16'(i);
            b_req_data  = 16'hB000 + 16'(i);
            b_req_rw    = 1'b1;
            @(negedge clk);
            check("b2b_rdy", b_req_ready, 1);
            if (i > 0) begin
                check("b2b_valid_o", valid_o, 1);
                check("b2b_addr_o", addr_o, 16'h0010 + 16'(i - 1));
            end
            tick();
        end
        b_req_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid_last", valid_o, 1);
        check("b2b_data_last", data_o, 16'hB007);
        check("b2b_rw_last", rw_o, 1);
        tick();
        @(negedge clk);
        check("b2b_valid_end", valid_o, 0);
        repeat (6) tick();
        n = rq.size() - base;
        check("b2b_count", n, 8);
        for (int j = 0; j < n && j < 8; j++) begin
            e = rq[base + j];
            check("b2b_port", e.port, 1);
            check("b2b_raddr", e.addr, 16'h0010 + 16'(j));
            check("b2b_rdata", e.data, 16'hB000 + 16'(j));
            check("b2b_rrw", e.rw, 1);
            check("b2b_consec", e.cyc - rq[base].cyc, j);
        end

        // ---- contention: A,B,A,B,A,B ----
        base = rq.size();
        begin
            int ai = 0;
            int bi = 0;
            for (int i = 0; i < 6; i++) begin
                a_req_valid = 1'b1; a_req_addr = 16'h0020 + 16'(ai); a_req_rw = 1'b0;
                b_req_valid = 1'b1; b_req_addr = 16'h0030 + 16'(bi); b_req_rw = 1'b0;
                @(negedge clk);
                check("cont_rdy_a", a_req_ready, (i % 2 == 0));
                check("cont_rdy_b", b_req_ready, (i % 2 == 1));
                tick();
                if (i % 2 == 0) ai++;
                else            bi++;
            end
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        repeat (6) tick();
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr = '{16'h0020, 16'h0030, 16'h0021, 16'h0031, 16'h0022, 16'h0032};
        n = rq.size() - base;
        check("cont_count", n, 6);
        for (int j = 0; j < n && j < 6; j++) begin
            e = rq[base + j];
            check("cont_port", e.port, exp_port[j]);
            check("cont_raddr", e.addr, exp_addr[j]);
            check("cont_rdata", e.data, exp_addr[j] ^ 16'hA5A5);
            check("cont_consec", e.cyc - rq[base].cyc, j);
        end

        // ---- reset mid-flight ----
        base = rq.size();
        a_req_valid = 1'b1; a_req_addr = 16'h0040; a_req_rw = 1'b0;
        @(negedge clk);
        check("mid_rdy0", a_req_ready, 1);
        tick();
        a_req_addr = 16'h0041;
        @(negedge clk);
        check("mid_rdy1", a_req_ready, 1);
        tick();
        a_req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req_valid = 1'b1; a_req_addr = 16'h0050; a_req_rw = 1'b0;
        b_req_valid = 1'b1; b_req_addr = 16'h0060; b_req_rw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) check("mid_valid_o_rst", valid_o, 0);
            check("mid_flush_rdy_a", a_req_ready, 0);
            check("mid_flush_rdy_b", b_req_ready, 0);
            check("mid_no_resp_a", a_resp_valid, 0);
            tick();
        end
        @(negedge clk);
        check("mid_startprio_a", a_req_ready, 1);
        check("mid_startprio_b", b_req_ready, 0);
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        repeat (6) tick();
        n = rq.size() - base;
        check("mid_count", n, 1);
        if (n > 0) begin
            check("mid_port", rq[base].port, 0);
            check("mid_addr", rq[base].addr, 16'h0050);
        end
        check("mid_err", err_o, 0);

        // ---- orphan return injection ----
        tick();
        @(negedge clk);
        check("inj_err_before", err_o, 0);
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        check("inj_err", err_o, EXP_ERR);
        check("inj_no_resp_a", a_resp_valid, 0);
        check("inj_no_resp_b", b_resp_valid, 0);
        repeat (3) tick();
        @(negedge clk);
        check("inj_err_sticky", err_o, EXP_ERR);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("inj_err_cleared", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
